// File: rtl/color_averager.sv
// ============================================================================
// color_averager -- averages 2^SAMPLES_LOG2 RGB sensor readings, reports the dominant channel
// Revision: 1.0
// ============================================================================
`default_nettype none

module color_averager #(
    parameter int SAMPLES_LOG2   = 2,
    parameter int GAP_CYCLES     = 100000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        sensor_ready,
    input  logic [15:0] sensor_red,
    input  logic [15:0] sensor_green,
    input  logic [15:0] sensor_blue,
    output logic        measure,
    output logic [15:0] avg_red,
    output logic [15:0] avg_green,
    output logic [15:0] avg_blue,
    output logic [1:0]  dominant,
    output logic        valid,
    output logic        timeout
);

    localparam int ACC_W = 16 + SAMPLES_LOG2;
    localparam int CNT_W = SAMPLES_LOG2 + 1;
    localparam logic [CNT_W-1:0] c_SAMPLES = CNT_W'(1 << SAMPLES_LOG2);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_RDY  = 3'd1;
    localparam logic [2:0] c_ST_TRIG      = 3'd2;
    localparam logic [2:0] c_ST_WAIT_BUSY = 3'd3;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] c_ST_ACCUM     = 3'd5;
    localparam logic [2:0] c_ST_OUTPUT    = 3'd6;
    localparam logic [2:0] c_ST_GAP       = 3'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;
    logic [ACC_W-1:0] r_acc_r;
    logic [ACC_W-1:0] r_acc_g;
    logic [ACC_W-1:0] r_acc_b;
    logic [31:0]      r_tcnt;
    logic [31:0]      r_gcnt;
    logic             r_run_d;
    logic             w_wait;
    logic             w_to_hit;
    logic             w_to_fire;
    logic             w_gap_done;
    logic [15:0]      w_avg_r;
    logic [15:0]      w_avg_g;
    logic [15:0]      w_avg_b;
    logic [1:0]       w_dom;

    logic             r_measure;
    logic             r_valid;
    logic             r_timeout;
    logic [15:0]      r_avg_r;
    logic [15:0]      r_avg_g;
    logic [15:0]      r_avg_b;
    logic [1:0]       r_dom;

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_last     = (w_cnt_inc == c_SAMPLES);
    assign w_wait     = (r_state == c_ST_WAIT_RDY) || (r_state == c_ST_WAIT_BUSY) ||
                        (r_state == c_ST_WAIT_DONE);
    assign w_to_hit   = w_wait && ((r_tcnt + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign w_gap_done = (r_gcnt + 32'd1) >= 32'(GAP_CYCLES);

    // Shift-and-truncate: the accumulator's top 16 bits are the average.
    assign w_avg_r = r_acc_r[ACC_W-1:SAMPLES_LOG2];
    assign w_avg_g = r_acc_g[ACC_W-1:SAMPLES_LOG2];
    assign w_avg_b = r_acc_b[ACC_W-1:SAMPLES_LOG2];

    always_comb begin
        w_dom = 2'd3;
        if ((w_avg_r > w_avg_g) && (w_avg_r > w_avg_b)) begin
            w_dom = 2'd0;
        end else if ((w_avg_g > w_avg_r) && (w_avg_g > w_avg_b)) begin
            w_dom = 2'd1;
        end else if ((w_avg_b > w_avg_r) && (w_avg_b > w_avg_g)) begin
            w_dom = 2'd2;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_to_fire = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (run) w_next = c_ST_WAIT_RDY;
            end
            c_ST_WAIT_RDY: begin
                if (!run) begin
                    w_next = c_ST_IDLE;
                end else if (sensor_ready) begin
                    w_next = c_ST_TRIG;
                end else if (w_to_hit) begin
                    w_next    = c_ST_IDLE;
                    w_to_fire = 1'b1;
                end
            end
            c_ST_TRIG: w_next = c_ST_WAIT_BUSY;
            c_ST_WAIT_BUSY: begin
                if (!sensor_ready) begin
                    w_next = c_ST_WAIT_DONE;
                end else if (w_to_hit) begin
                    w_next    = c_ST_IDLE;
                    w_to_fire = 1'b1;
                end
            end
            c_ST_WAIT_DONE: begin
                if (sensor_ready) begin
                    w_next = c_ST_ACCUM;
                end else if (w_to_hit) begin
                    w_next    = c_ST_IDLE;
                    w_to_fire = 1'b1;
                end
            end
            // The reading in flight is always taken; a dropped run only stops the next trigger.
            c_ST_ACCUM: begin
                if (w_last)    w_next = c_ST_OUTPUT;
                else if (!run) w_next = c_ST_IDLE;
                else           w_next = c_ST_TRIG;
            end
            c_ST_OUTPUT: w_next = c_ST_GAP;
            c_ST_GAP: begin
                if (!run)            w_next = c_ST_IDLE;
                else if (w_gap_done) w_next = c_ST_WAIT_RDY;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_acc_r   <= '0;
            r_acc_g   <= '0;
            r_acc_b   <= '0;
            r_tcnt    <= '0;
            r_gcnt    <= '0;
            r_run_d   <= 1'b0;
            r_measure <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_avg_r   <= '0;
            r_avg_g   <= '0;
            r_avg_b   <= '0;
            r_dom     <= 2'd3;
        end else begin
            r_state   <= w_next;
            r_run_d   <= run;
            r_measure <= (w_next == c_ST_TRIG);
            r_valid   <= (r_state == c_ST_OUTPUT);

            if (w_wait && (w_next == r_state)) r_tcnt <= r_tcnt + 32'd1;
            else                               r_tcnt <= '0;

            if ((r_state == c_ST_GAP) && (w_next == c_ST_GAP)) r_gcnt <= r_gcnt + 32'd1;
            else                                               r_gcnt <= '0;

            if (r_state == c_ST_ACCUM) begin
                r_acc_r <= r_acc_r + ACC_W'(sensor_red);
                r_acc_g <= r_acc_g + ACC_W'(sensor_green);
                r_acc_b <= r_acc_b + ACC_W'(sensor_blue);
                r_cnt   <= w_cnt_inc;
            end else if ((r_state == c_ST_IDLE) || (r_state == c_ST_OUTPUT) || w_to_fire) begin
                r_acc_r <= '0;
                r_acc_g <= '0;
                r_acc_b <= '0;
                r_cnt   <= '0;
            end

            if (r_state == c_ST_OUTPUT) begin
                r_avg_r <= w_avg_r;
                r_avg_g <= w_avg_g;
                r_avg_b <= w_avg_b;
                r_dom   <= w_dom;
            end

            if (w_to_fire)          r_timeout <= 1'b1;
            else if (run && !r_run_d) r_timeout <= 1'b0;
        end
    end

    assign measure   = r_measure;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign avg_red   = r_avg_r;
    assign avg_green = r_avg_g;
    assign avg_blue  = r_avg_b;
    assign dominant  = r_dom;

endmodule

`default_nettype wire

// File: tb/tb_color_averager.sv
// ============================================================================
// tb_color_averager -- directed checks of color_averager against a simple sensor model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_color_averager;

    logic        clk;
    logic        rst;
    logic        run;
    logic        sensor_ready;
    logic [15:0] sensor_red;
    logic [15:0] sensor_green;
    logic [15:0] sensor_blue;
    logic        measure;
    logic [15:0] avg_red;
    logic [15:0] avg_green;
    logic [15:0] avg_blue;
    logic [1:0]  dominant;
    logic        valid;
    logic        timeout;

    int n_checks    = 0;
    int n_pass      = 0;
    int meas_count  = 0;
    int valid_count = 0;
    int dbl_meas    = 0;
    int rd_base     = 0;
    int vb          = 0;
    logic stuck     = 1'b0;
    logic prev_meas = 1'b0;
    logic [15:0] rd_r [8];
    logic [15:0] rd_g [8];
    logic [15:0] rd_b [8];

    color_averager #(
        .SAMPLES_LOG2   (2),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .sensor_ready (sensor_ready),
        .sensor_red   (sensor_red),
        .sensor_green (sensor_green),
        .sensor_blue  (sensor_blue),
        .measure      (measure),
        .avg_red      (avg_red),
        .avg_green    (avg_green),
        .avg_blue     (avg_blue),
        .dominant     (dominant),
        .valid        (valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sensor: on measure, drop ready, then return ready with the next table entry.
    initial begin
        int idx;
        sensor_ready = 1'b1;
        sensor_red   = '0;
        sensor_green = '0;
        sensor_blue  = '0;
        forever begin
            @(negedge clk);
            if (measure === 1'b1) begin
                idx = (meas_count - rd_base) % 8;
                meas_count++;
                if (!stuck) begin
                    sensor_ready = 1'b0;
                    repeat (3) @(negedge clk);
                    sensor_red   = rd_r[idx];
                    sensor_green = rd_g[idx];
                    sensor_blue  = rd_b[idx];
                    sensor_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) valid_count++;
            if ((measure === 1'b1) && prev_meas) dbl_meas++;
            prev_meas = (measure === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int target);
        for (int k = 0; k < 500 && valid_count < target; k++) begin
            @(negedge clk);
            #1;
        end
        check("wait_valid", 32'(valid_count >= target), 32'd1);
    endtask

    task automatic wait_meas(input int target);
        for (int k = 0; k < 500 && meas_count < target; k++) begin
            @(negedge clk);
            #1;
        end
        check("wait_measure", 32'(meas_count >= target), 32'd1);
    endtask

    task automatic set_reads(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                             input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rd_r[i] = r;
            rd_g[i] = g;
            rd_b[i] = b;
        end
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        set_reads(16'd0, 16'd0, 16'd0, 0, 7);
        wait_cycles(3);
        check("rst_measure", 32'(measure), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_avg_red", 32'(avg_red), 32'd0);
        check("rst_avg_green", 32'(avg_green), 32'd0);
        check("rst_avg_blue", 32'(avg_blue), 32'd0);
        check("rst_dominant", 32'(dominant), 32'd3);
        rst = 1'b1;
        wait_cycles(2);

        // Four identical readings.
        set_reads(16'd100, 16'd200, 16'd300, 0, 7);
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        wait_valid(vb + 1);
        run = 1'b0;
        check("basic_measure_count", 32'(meas_count - rd_base), 32'd4);
        check("basic_avg_red", 32'(avg_red), 32'd100);
        check("basic_avg_green", 32'(avg_green), 32'd200);
        check("basic_avg_blue", 32'(avg_blue), 32'd300);
        check("basic_dominant", 32'(dominant), 32'd2);
        wait_cycles(3);

        // 1+2+3+5 = 11, 11>>2 = 2.
        set_reads(16'd0, 16'd0, 16'd0, 0, 7);
        rd_r[0] = 16'd1; rd_r[1] = 16'd2; rd_r[2] = 16'd3; rd_r[3] = 16'd5;
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        wait_valid(vb + 1);
        run = 1'b0;
        check("trunc_avg_red", 32'(avg_red), 32'd2);
        check("trunc_avg_green", 32'(avg_green), 32'd0);
        check("trunc_dominant", 32'(dominant), 32'd0);
        wait_cycles(3);

        // Tie, then all zero, back to back through the gap with run held.
        set_reads(16'd500, 16'd500, 16'd10, 0, 3);
        set_reads(16'd0, 16'd0, 16'd0, 4, 7);
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        wait_valid(vb + 1);
        check("tie_avg_green", 32'(avg_green), 32'd500);
        check("tie_dominant", 32'(dominant), 32'd3);
        wait_valid(vb + 2);
        run = 1'b0;
        check("zero_avg_red", 32'(avg_red), 32'd0);
        check("zero_dominant", 32'(dominant), 32'd3);
        check("two_results_measures", 32'(meas_count - rd_base), 32'd8);
        wait_cycles(3);

        // Full-scale readings must not overflow.
        set_reads(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 7);
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        wait_valid(vb + 1);
        run = 1'b0;
        check("max_avg_red", 32'(avg_red), 32'hFFFF);
        check("max_avg_green", 32'(avg_green), 32'hFFFF);
        check("max_avg_blue", 32'(avg_blue), 32'hFFFF);
        wait_cycles(3);

        // run dropped while waiting for the reading to finish.
        set_reads(16'd7, 16'd8, 16'd9, 0, 7);
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        wait_meas(rd_base + 1);
        wait_cycles(2);
        run = 1'b0;
        wait_cycles(30);
        check("drop_measure_count", 32'(meas_count - rd_base), 32'd1);
        check("drop_no_valid", 32'(valid_count - vb), 32'd0);
        check("drop_avg_kept", 32'(avg_red), 32'hFFFF);

        // Sensor never goes busy -> handshake timeout.
        stuck = 1'b1;
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        for (int k = 0; k < 200 && timeout !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        run = 1'b0;
        check("timeout_set", 32'(timeout), 32'd1);
        wait_cycles(10);
        check("timeout_sticky", 32'(timeout), 32'd1);
        check("timeout_no_valid", 32'(valid_count - vb), 32'd0);
        check("timeout_one_measure", 32'(meas_count - rd_base), 32'd1);
        stuck = 1'b0;
        run = 1'b1;
        wait_cycles(1);
        check("timeout_cleared_by_run", 32'(timeout), 32'd0);
        run = 1'b0;
        wait_cycles(5);

        // Asynchronous reset while the sensor is busy.
        set_reads(16'd100, 16'd200, 16'd300, 0, 7);
        rd_base = meas_count;
        vb = valid_count;
        run = 1'b1;
        wait_meas(rd_base + 1);
        wait_cycles(1);
        #2;
        rst = 1'b0;
        run = 1'b0;
        #1;
        check("arst_avg_red", 32'(avg_red), 32'd0);
        check("arst_avg_green", 32'(avg_green), 32'd0);
        check("arst_avg_blue", 32'(avg_blue), 32'd0);
        check("arst_dominant", 32'(dominant), 32'd3);
        check("arst_measure", 32'(measure), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        wait_cycles(3);
        rst = 1'b1;
        wait_cycles(20);
        check("arst_no_valid", 32'(valid_count - vb), 32'd0);
        check("arst_idle_no_measure", 32'(meas_count - rd_base), 32'd1);

        // Normal operation resumes after reset.
        rd_base = meas_count;
        run = 1'b1;
        wait_valid(vb + 1);
        run = 1'b0;
        check("resume_avg_green", 32'(avg_green), 32'd200);
        check("resume_dominant", 32'(dominant), 32'd2);
        wait_cycles(3);

        check("no_back_to_back_measure", 32'(dbl_meas), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
